// File: rtl/mul_radix8_seq_if.sv
// mul_radix8_seq_if: request/result bundle between a requester and the radix-8 multiplier
interface mul_radix8_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, A, B, input Busy, Done, Hi, Lo);
  modport slave (input Start, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/mul_radix8_seq.sv
// mul_radix8_seq: sequential 32x32 unsigned multiplier retiring three multiplier bits per cycle
module mul_radix8_seq #(
  parameter int WIDTH = 32
) (
  input logic Clk,
  input logic RstN,
  mul_radix8_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRECALC, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] m_q;
  logic [32:0] l_q;
  logic [35:0] h_q;
  logic [3:0] cnt_q;
  logic [34:0] mul_q [8];
  logic [31:0] hi_q, lo_q;
  logic accept;
  logic [35:0] sum_d;
  logic [68:0] hl_d;
  // A new request is only taken when no operation is in flight.
  assign accept = bus.Start && (state_q == IDLE || state_q == DONE);
  // Entry 0 of the multiple table is never written with anything but zero.
  assign sum_d = h_q + {1'b0, mul_q[l_q[2:0]]};
  assign hl_d = 69'({3'b0, sum_d, l_q} >> 3);
  // State register; reset wins over any request at the same edge.
  always_ff @(posedge Clk) begin
    if (!RstN) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next-state: one precompute cycle, eleven accumulate cycles, one result cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.Start ? PRECALC : IDLE;
      PRECALC:    state_d = RUN;
      RUN:        state_d = (cnt_q == 4'd10) ? DONE : RUN;
      default:    state_d = IDLE;
    endcase
  end
  // Status and result outputs decoded from registered state.
  always_comb begin
    bus.Busy = (state_q == PRECALC) || (state_q == RUN);
    bus.Done = state_q == DONE;
    bus.Hi = hi_q;
    bus.Lo = lo_q;
  end
  // Datapath: operand capture, multiple table, shift-accumulate and result latch.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      m_q <= '0;
      l_q <= '0;
      h_q <= '0;
      cnt_q <= '0;
      mul_q <= '{default: '0};
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        m_q <= bus.A;
        l_q <= {1'b0, bus.B};
        h_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == PRECALC)
        for (int k = 0; k < 8; k++) mul_q[k] <= 35'(m_q) * 35'(k);
      if (state_q == RUN) begin
        h_q <= hl_d[68:33];
        l_q <= hl_d[32:0];
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          hi_q <= hl_d[63:32];
          lo_q <= hl_d[31:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_mul_radix8_seq.sv
// tb_mul_radix8_seq: scoreboard bench comparing every completion against a 64-bit reference product
module tb_mul_radix8_seq;
  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit rst_seen = 1'b0;
  logic [63:0] exp_hl = '0;
  exp_t sb[$];
  mul_radix8_seq_if bus_if ();
  mul_radix8_seq dut (.Clk(clk), .RstN(rst_n), .bus(bus_if));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !rst_n;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  // Monitor: pops one expectation per Done and checks result hold between completions.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) exp_hl = '0;
      if (bus_if.Done === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("product", {bus_if.Hi, bus_if.Lo}, e.prod);
          exp_hl = e.prod;
        end
      end
      chk("hilo_hold", {bus_if.Hi, bus_if.Lo}, exp_hl);
    end
  end
  // Issues one operation from the posedge+1 phase and returns in IDLE, same phase.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit check_busy);
    exp_t e;
    bus_if.Start = 1'b1;
    bus_if.A = a;
    bus_if.B = b;
    @(posedge clk);
    #1;
    e.prod = 64'(a) * 64'(b);
    e.due = cyc + 12;
    sb.push_back(e);
    bus_if.Start = 1'b0;
    bus_if.A = $urandom;
    bus_if.B = $urandom;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (check_busy) begin
        chk("busy_run", 64'(bus_if.Busy), 64'd1);
        chk("done_early", 64'(bus_if.Done), 64'd0);
      end
      if (i == 5) bus_if.Start = 1'b1;
      @(posedge clk);
      #1;
      bus_if.Start = 1'b0;
    end
    @(negedge clk);
    chk("busy_done", 64'(bus_if.Busy), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    logic [31:0] a, b;
    rst_n = 1'b0;
    bus_if.Start = 1'b1;
    bus_if.A = 32'd7;
    bus_if.B = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.Start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus_if.Busy), 64'd0);
    chk("rst_done", 64'(bus_if.Done), 64'd0);
    chk("rst_hilo", {bus_if.Hi, bus_if.Lo}, 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_no_start", 64'(bus_if.Busy), 64'd0);
    @(posedge clk);
    #1;
    run(32'd7, 32'd7, 1'b1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run(32'h8000_0000, 32'd3, 1'b0);
    run(32'd0, 32'h1234_5678, 1'b0);
    bus_if.Start = 1'b1;
    bus_if.A = 32'hFFFF_FFFF;
    bus_if.B = 32'd2;
    @(posedge clk);
    #1;
    e.prod = 64'h1_FFFF_FFFE;
    e.due = cyc + 12;
    sb.push_back(e);
    bus_if.A = 32'd3;
    bus_if.B = 32'd5;
    repeat (13) @(posedge clk);
    #1;
    e.prod = 64'd15;
    e.due = cyc + 12;
    sb.push_back(e);
    bus_if.Start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    bus_if.Start = 1'b1;
    bus_if.A = 32'd5;
    bus_if.B = 32'd9;
    @(posedge clk);
    #1;
    bus_if.Start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(bus_if.Busy), 64'd0);
    chk("abort_hilo", {bus_if.Hi, bus_if.Lo}, 64'd0);
    repeat (15) @(posedge clk);
    #1;
    run(32'd5, 32'd9, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i < 8) b[2:0] = 3'(i);
      else if (i < 16) b[31] = 1'b1;
      run(a, b, 1'b0);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_radix8_seq.md
Name: mul_radix8_seq

Overview:
- Sequential unsigned 32x32 multiplier. It retires 3 multiplier bits per clock (radix-8) and produces a 64-bit product as Hi/Lo for the MIPS HI/LO registers.
- It is the consumer stage around the 8-way multiple-select mux. Each cycle it derives the 3-bit select from the multiplier, picks one of eight precomputed multiples {0,1..7}xA and accumulates it.
- Multiples are 35 bits wide, so the select and accumulate path is internal to this block.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported and verified; the group count is fixed at 11 (33 bits, MSB zero-padded).

Ports:
- Clk    input   1   rising-edge clock, the single clock domain.
- RstN   input   1   synchronous active-low reset, sampled on rising Clk.
- Start  input   1   request; sampled only in IDLE or DONE.
- A      input   32  multiplicand (unsigned), captured when Start is accepted.
- B      input   32  multiplier (unsigned), captured when Start is accepted.
- Busy   output  1   high while an operation is in PRECALC or RUN.
- Done   output  1   one-cycle pulse: Hi/Lo are valid from this cycle onward.
- Hi     output  32  product[63:32], held until the next accepted Start.
- Lo     output  32  product[31:0], held until the next accepted Start.

Behaviour:
- Reset: when RstN is low at a clock edge, the state goes to IDLE. Busy=0, Done=0, Hi=0, Lo=0, and all internal registers clear. Reset wins over Start at the same edge. Reset mid-operation aborts the operation; no Done follows.
- States: IDLE, PRECALC, RUN, DONE.
- IDLE: when Start=1, capture A into Mreg and {1'b0,B} into L (33 bits). Clear H (36 bits) and Cnt. Go to PRECALC. Hi/Lo keep their old values until DONE.
- PRECALC (1 cycle): register M1=A, M2=2A, M3=3A, M4=4A, M5=5A, M6=6A, M7=7A, all 35-bit zero-extended. Go to RUN.
- RUN (11 cycles, Cnt 0..10):
  - sel = L[2:0]; mult = table[sel], where table[0]=0.
  - sum = H + mult (36 bits, no overflow possible).
  - {H,L} <= {3'b0, sum, L} >> 3, i.e. a 69-bit concatenation shifted right by 3.
  - Cnt <= Cnt+1.
  - When Cnt==10, also go to DONE.
- DONE (1 cycle): Hi/Lo <= bits [63:32]/[31:0] of {H,L}, and Done=1 registered in the same edge as entry. If Start=1 in DONE, accept it exactly as in IDLE and go to PRECALC. Otherwise go to IDLE.
- Latency: Start sampled at edge E0, then PRECALC through E1, RUN through E12. Done=1 and Hi/Lo are valid in the cycle after E12, i.e. 12 edges after acceptance. Back-to-back issue gives one result every 13 cycles.
- Busy is high in PRECALC and RUN, and low in IDLE and DONE.
- Start while Busy=1 is ignored: no queueing, no error.
- A/B changes after acceptance have no effect.
- Done is never high for more than one consecutive cycle unless Start is re-accepted and the next completion falls adjacent. That cannot happen, since the minimum period is 13 cycles.

Test Plan:
- RstN=0 for 2 cycles, then 1 -> Busy=0, Done=0, Hi=0, Lo=0. Start=1 with RstN=0 -> no operation begins.
- A=7, B=7, Start pulse -> Done exactly 12 edges later; Hi=0x00000000, Lo=0x00000031; Busy high for 11... 12 cycles before Done (PRECALC + 11 RUN).
- A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then A=0x80000000, B=3 -> Hi=0x00000001, Lo=0x80000000. Then A=0, B=0x12345678 -> Hi=0, Lo=0.
- Start held high continuously with A=0xFFFFFFFF, B=2 -> first Done after 12 edges with Hi=0x00000001, Lo=0xFFFFFFFE. The Start pulses asserted during Busy are ignored. The next operation is accepted in the DONE cycle and its Done arrives 13 cycles after the first.
- Mid-operation: after Start (A=5, B=9), drive RstN=0 at the 6th RUN cycle -> next cycle in IDLE, Hi/Lo=0, no Done. A fresh Start with A=5, B=9 -> Lo=0x0000002D.
- Random: 1000 random A/B pairs, including all B low-group patterns 0..7 and B[31]=1 -> {Hi,Lo} equals the 64-bit reference product. Hi/Lo stay stable between Done pulses.
